// File: rtl/result_face_display.sv
// End-of-game matrix animator: scans a win or fail face on the dot matrix with a
// mode-specific buzzer tone, then blanks, pulses repeat_rst and waits for the triggers to drop.
module result_face_display #(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int SCAN_DIV    = 1000,
  parameter int TONE_LO_DIV = 1000,
  parameter int TONE_HI_DIV = 500,
  parameter int GATE_DIV    = 250000,
  parameter int SHOW_CYCLES = 2500000,
  parameter logic [ROWS*COLS-1:0] FAIL_IMG = 64'h8142244281182442,
  parameter logic [ROWS*COLS-1:0] WIN_IMG  = 64'h0066660081423C00
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            win,
  input  logic            fail,
  output logic [ROWS-1:0] hang,
  output logic [COLS-1:0] red,
  output logic            beep,
  output logic            repeat_rst,
  output logic            busy
);
  localparam int TONE_MAX = (TONE_LO_DIV > TONE_HI_DIV) ? TONE_LO_DIV : TONE_HI_DIV;
  localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int TONE_W   = (TONE_MAX > 1) ? $clog2(TONE_MAX) : 1;
  localparam int GATE_W   = (GATE_DIV > 1) ? $clog2(GATE_DIV) : 1;
  localparam int DUR_W    = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

  localparam logic [ROW_W-1:0]  ROW_LAST     = ROW_W'(ROWS - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST    = SCAN_W'(SCAN_DIV - 1);
  localparam logic [TONE_W-1:0] TONE_LO_LAST = TONE_W'(TONE_LO_DIV - 1);
  localparam logic [TONE_W-1:0] TONE_HI_LAST = TONE_W'(TONE_HI_DIV - 1);
  localparam logic [GATE_W-1:0] GATE_LAST    = GATE_W'(GATE_DIV - 1);
  localparam logic [DUR_W-1:0]  DUR_LAST     = DUR_W'(SHOW_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHOW, DONE, WAIT_CLR} state_t;

  state_t              state_q;
  logic                mode_q;   // 1 = win face / high chirped tone, 0 = fail face / low tone
  logic [ROW_W-1:0]    row_q;
  logic [SCAN_W-1:0]   scan_q;
  logic [TONE_W-1:0]   tone_q;
  logic [GATE_W-1:0]   gcnt_q;
  logic                gate_q;
  logic [DUR_W-1:0]    dur_q;

  logic [ROW_W-1:0]    row_d;
  logic [TONE_W-1:0]   tone_last;

  function automatic logic [COLS-1:0] img_row(input logic win_mode, input logic [ROW_W-1:0] r);
    logic [ROWS*COLS-1:0] sh;
    logic [ROW_W-1:0]     idx;
    idx = ROW_LAST - r;
    sh  = (win_mode ? WIN_IMG : FAIL_IMG) >> (int'(idx) * COLS);
    return sh[COLS-1:0];
  endfunction

  function automatic logic [ROWS-1:0] row_sel(input logic [ROW_W-1:0] r);
    logic [ROWS-1:0] s;
    s    = '0;
    s[0] = 1'b1;
    return ~(s << (ROW_LAST - r));
  endfunction

  always_comb begin
    row_d = row_q;
    if (scan_q == SCAN_LAST) row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    tone_last = mode_q ? TONE_HI_LAST : TONE_LO_LAST;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      row_q      <= '0;
      scan_q     <= '0;
      tone_q     <= '0;
      gcnt_q     <= '0;
      gate_q     <= 1'b0;
      dur_q      <= '0;
      hang       <= '1;
      red        <= '0;
      beep       <= 1'b0;
      repeat_rst <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fail || win) begin
            state_q <= SHOW;
            mode_q  <= !fail;
            row_q   <= '0;
            scan_q  <= '0;
            tone_q  <= '0;
            gcnt_q  <= '0;
            gate_q  <= 1'b1;
            dur_q   <= '0;
            hang    <= row_sel('0);
            red     <= img_row(!fail, '0);
            beep    <= 1'b0;
            busy    <= 1'b1;
          end
        end
        SHOW: begin
          if (dur_q == DUR_LAST) begin
            state_q    <= DONE;
            hang       <= '1;
            red        <= '0;
            beep       <= 1'b0;
            repeat_rst <= 1'b1;
          end else begin
            dur_q  <= dur_q + 1'b1;
            scan_q <= (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
            row_q  <= row_d;
            hang   <= row_sel(row_d);
            red    <= img_row(mode_q, row_d);
            gcnt_q <= (gcnt_q == GATE_LAST) ? '0 : gcnt_q + 1'b1;
            if (gcnt_q == GATE_LAST) gate_q <= !gate_q;
            // Win chirp: the gate mutes the buzzer and parks the tone phase at 0.
            if (mode_q && !gate_q) begin
              tone_q <= '0;
              beep   <= 1'b0;
            end else if (tone_q == tone_last) begin
              tone_q <= '0;
              beep   <= !beep;
            end else begin
              tone_q <= tone_q + 1'b1;
            end
          end
        end
        DONE: begin
          repeat_rst <= 1'b0;
          state_q    <= WAIT_CLR;
        end
        WAIT_CLR: begin
          if (!win && !fail) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_result_face_display.sv
// Randomised bench for result_face_display against a timeline model of the display
// (phase plus cycles-since-entry, outputs derived arithmetically from the face images).
module tb_result_face_display;
  localparam int ROWS = 8, COLS = 8, SCAN_DIV = 2, TONE_LO_DIV = 3, TONE_HI_DIV = 1;
  localparam int GATE_DIV = 4, SHOW_CYCLES = 40;
  localparam logic [63:0] FAIL_IMG = 64'h8142244281182442;
  localparam logic [63:0] WIN_IMG  = 64'h0066660081423C00;

  logic clk = 1'b0, rst = 1'b1, win = 1'b0, fail = 1'b0;
  logic [ROWS-1:0] hang;
  logic [COLS-1:0] red;
  logic beep, repeat_rst, busy;

  result_face_display #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .TONE_LO_DIV(TONE_LO_DIV),
    .TONE_HI_DIV(TONE_HI_DIV), .GATE_DIV(GATE_DIV), .SHOW_CYCLES(SHOW_CYCLES),
    .FAIL_IMG(FAIL_IMG), .WIN_IMG(WIN_IMG)
  ) dut (
    .clk(clk), .rst(rst), .win(win), .fail(fail), .hang(hang), .red(red),
    .beep(beep), .repeat_rst(repeat_rst), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  int rr_seen = 0;
  always @(posedge repeat_rst) rr_seen++;

  typedef enum int {P_IDLE, P_SHOW, P_DONE, P_WAIT} phase_t;
  phase_t ph = P_IDLE;
  int     k = 0;
  bit     m_win = 1'b0;

  logic [7:0] hang_tab [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
  logic [7:0] red_tab  [8] = '{8'h81, 8'h42, 8'h24, 8'h42, 8'h81, 8'h18, 8'h24, 8'h42};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] img_byte(input bit w, input int r);
    logic [63:0] img;
    img = w ? WIN_IMG : FAIL_IMG;
    return img[(7 - r) * 8 +: 8];
  endfunction

  task automatic check_outputs(input string where);
    logic [7:0] eh, er;
    logic eb, erep, ebusy;
    int row;
    eh = 8'hFF; er = 8'h00; eb = 1'b0; erep = 1'b0;
    ebusy = (ph != P_IDLE);
    if (ph == P_SHOW) begin
      row = (k / SCAN_DIV) % ROWS;
      eh  = 8'hFF ^ (8'h80 >> row);
      er  = img_byte(m_win, row);
      if (m_win) eb = ((k / GATE_DIV) % 2 == 0) ? 1'((k % (2 * GATE_DIV)) / TONE_HI_DIV % 2) : 1'b0;
      else       eb = 1'((k / TONE_LO_DIV) % 2);
    end
    if (ph == P_DONE) erep = 1'b1;
    chk({where, ".hang"}, 32'(hang), 32'(eh));
    chk({where, ".red"},  32'(red),  32'(er));
    chk({where, ".beep"}, 32'(beep), 32'(eb));
    chk({where, ".repeat_rst"}, 32'(repeat_rst), 32'(erep));
    chk({where, ".busy"}, 32'(busy), 32'(ebusy));
  endtask

  task automatic model_edge();
    if (rst) begin
      ph = P_IDLE; k = 0;
      return;
    end
    case (ph)
      P_IDLE: if (fail || win) begin ph = P_SHOW; k = 0; m_win = !fail; end
      P_SHOW: if (k == SHOW_CYCLES - 1) ph = P_DONE; else k++;
      P_DONE: ph = P_WAIT;
      P_WAIT: if (!fail && !win) ph = P_IDLE;
      default: ph = P_IDLE;
    endcase
  endtask

  task automatic step(input string where);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(where);
  endtask

  task automatic run_to_idle(input string where);
    int n;
    win = 1'b0; fail = 1'b0;
    n = 0;
    while (ph != P_IDLE && n < 200) begin
      step(where);
      n++;
    end
    chk({where, ".idle_timeout"}, 32'(ph == P_IDLE), 32'd1);
  endtask

  // Caller is at posedge+1; reset goes high mid-cycle and must blank without an edge.
  task automatic async_reset(input string where);
    #3 rst = 1'b1;
    #1;
    ph = P_IDLE; k = 0;
    chk({where, ".async_hang"}, 32'(hang), 32'hFF);
    chk({where, ".async_red"},  32'(red),  32'h00);
    chk({where, ".async_beep"}, 32'(beep), 32'h0);
    check_outputs(where);
    step(where);
    rst = 1'b0;
  endtask

  initial begin
    int first_rr, rr_before, hold;

    // Reset, with a trigger held that must be ignored
    fail = 1'b1;
    for (int i = 0; i < 3; i++) step("reset");
    fail = 1'b0;
    rst  = 1'b0;
    step("idle");

    // Fail scan against the literal row table
    fail = 1'b1;
    step("fail_scan");
    fail = 1'b0;
    for (int i = 0; i < 18; i++) begin
      chk("fail_scan.tab_hang", 32'(hang), 32'(hang_tab[(i / 2) % 8]));
      chk("fail_scan.tab_red",  32'(red),  32'(red_tab[(i / 2) % 8]));
      step("fail_scan");
    end
    run_to_idle("fail_scan");

    // Both triggers on the same edge: fail wins
    win = 1'b1; fail = 1'b1;
    step("priority");
    chk("priority.red", 32'(red), 32'h81);
    run_to_idle("priority");

    // Win face
    win = 1'b1;
    step("win");
    win = 1'b0;
    step("win"); step("win");
    chk("win.row1_hang", 32'(hang), 32'hBF);
    chk("win.row1_red",  32'(red),  32'h66);
    run_to_idle("win");

    // Completion with fail held, then re-arm
    fail = 1'b1;
    rr_before = rr_seen;
    first_rr = -1;
    for (int i = 1; i <= 60; i++) begin
      step("complete");
      if (repeat_rst === 1'b1 && first_rr < 0) first_rr = i;
    end
    chk("complete.rr_step", 32'(first_rr), 32'd41);
    chk("complete.rr_count", 32'(rr_seen - rr_before), 32'd1);
    chk("complete.busy_held", 32'(busy), 32'd1);
    fail = 1'b0;
    step("rearm");
    chk("rearm.busy", 32'(busy), 32'd0);
    fail = 1'b1;
    step("rearm");
    fail = 1'b0;
    chk("rearm.hang", 32'(hang), 32'h7F);
    chk("rearm.red",  32'(red),  32'h81);
    run_to_idle("rearm");

    // Reset during row 3
    fail = 1'b1;
    step("midrst");
    fail = 1'b0;
    for (int i = 0; i < 6; i++) step("midrst");
    chk("midrst.row3_hang", 32'(hang), 32'hEF);
    rr_before = rr_seen;
    async_reset("midrst");
    for (int i = 0; i < 5; i++) step("midrst");
    chk("midrst.no_rr", 32'(rr_seen - rr_before), 32'd0);

    // Randomised triggers, hold lengths and occasional resets
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        fail = ($urandom_range(0, 9) == 0);
        win  = ($urandom_range(0, 7) == 0);
        hold = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 70) : $urandom_range(0, 6);
      end else begin
        hold--;
      end
      if ($urandom_range(0, 399) == 0) async_reset("rand");
      else step("rand");
    end
    run_to_idle("rand");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/result_face_display.md
Name: result_face_display

Overview:
Parametrised end-of-game matrix animator and sounder. It replaces the single-purpose fail face driver. On a win or fail trigger it scans a ROWS x COLS LED image and drives a mode-specific tone on the buzzer. After a fixed display time it blanks, issues a one-cycle game-restart pulse, and re-arms once both triggers are released. It sits between the game-control FSM and the dot-matrix and buzzer pins.

Parameters:
ROWS, 8, matrix row count (hang width)
COLS, 8, matrix column count (red width)
SCAN_DIV, 1000, clock cycles each row is held
TONE_LO_DIV, 1000, beep half-period in cycles, fail mode (low tone)
TONE_HI_DIV, 500, beep half-period in cycles, win mode (high tone)
GATE_DIV, 250000, win-mode chirp on/off half-period in cycles
SHOW_CYCLES, 2500000, total display duration in cycles
FAIL_IMG, 64'h8142244281182442, ROWS*COLS bits; row r = bits [(ROWS-1-r)*COLS +: COLS]
WIN_IMG, 64'h0066660081423C00, same layout, smiley

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
win  in  1  level trigger: show win face
fail  in  1  level trigger: show fail face
hang  out  ROWS  row select, active-low one-hot; row r drives bit ROWS-1-r
red  out  COLS  column data for the selected row, active-high
beep  out  1  buzzer square wave
repeat_rst  out  1  one-cycle pulse requesting a game reset
busy  out  1  high whenever the block is not in IDLE

Behaviour:
- Clocking: one clock, clk. Reset: rst, asynchronous, active-high.
- Reset values: hang all ones, red 0, beep 0, repeat_rst 0, busy 0, state IDLE, all counters 0. Reset asserted mid-animation blanks immediately and asynchronously; no repeat_rst is produced.
- States: IDLE -> SHOW -> DONE -> WAIT_CLR -> IDLE. All outputs are registered.
- IDLE:
  - On an edge with fail=1, go to SHOW with mode=FAIL.
  - Else, on an edge with win=1, go to SHOW with mode=WIN.
  - fail has priority when both are high.
  - On that same edge: hang=row 0 select, red=row 0 of the image, busy=1, row/scan/tone/gate/duration counters cleared.
- SHOW:
  - mode is latched on entry; win/fail changes are ignored.
  - Scan counter runs 0..SCAN_DIV-1. On SCAN_DIV-1 it wraps and the row index advances; ROWS-1 wraps to 0. Each row is held exactly SCAN_DIV cycles.
  - red always equals the current row of the image selected by mode.
- Beep:
  - FAIL: toggles each time the tone counter reaches TONE_LO_DIV-1, then the counter wraps to 0.
  - WIN: tone counter uses TONE_HI_DIV. A gate flag starts at 1 and toggles every GATE_DIV cycles. While the gate is 0, beep is forced to 0 and the tone counter holds at 0.
- Duration: a counter counts cycles in SHOW. When it reaches SHOW_CYCLES-1 (SHOW lasted exactly SHOW_CYCLES cycles), go to DONE.
- DONE (1 cycle): hang all ones, red 0, beep 0, repeat_rst=1. Next edge: repeat_rst=0, go to WAIT_CLR.
- WAIT_CLR: outputs stay blank, busy=1. Go to IDLE on the first edge with win=0 and fail=0, so a held trigger cannot retrigger. If both are already low, the stay is exactly one cycle.
- Counter widths: $clog2 of the respective limit, minimum 1 bit. All arithmetic is unsigned and wraps only at the stated limits.

Test Plan:
All scenarios use ROWS=8, COLS=8, SCAN_DIV=2, TONE_LO_DIV=3, TONE_HI_DIV=1, GATE_DIV=4, SHOW_CYCLES=40.
1. Reset: rst=1 for 3 cycles -> hang=FF, red=00, beep=0, repeat_rst=0, busy=0. Triggers are ignored while rst is high.
2. Fail scan: fail pulse for 1 cycle -> the following sequence, each row held 2 cycles, then wrap to 7F/81. beep toggles every 3 cycles; busy=1.
   - 7F/81, BF/42, DF/24, EF/42
   - F7/81, FB/18, FD/24, FE/42
3. Priority: win=1 and fail=1 on the same edge -> FAIL image is shown (first row red=81), low tone.
4. Win mode: win pulse -> row 1 shows hang=BF, red=66. beep toggles every cycle for 4 cycles, then is 0 for 4 cycles, repeating.
5. Completion and re-arm: fail held high -> after exactly 40 SHOW cycles, outputs blank and repeat_rst=1 for exactly 1 cycle. busy stays 1 while fail is high with no restart. Drop fail -> IDLE on the next edge; a new fail pulse restarts at row 0.
6. Mid-run reset: rst asserted during row 3 -> hang=FF, red=00, beep=0 without waiting for a clock edge. repeat_rst never pulses; after release the block is in IDLE.
